// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// Registers operands, captures the result, returns it via valid/ready.
module alu_arbiter #(
   parameter int DATA_W = 32,
   parameter int CTRL_W = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_op1,
   input  logic [DATA_W-1:0] req0_op2,
   input  logic [DATA_W-1:0] req0_immx,
   input  logic              req0_isImmediate,
   input  logic [CTRL_W-1:0] req0_aluSignals,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_op1,
   input  logic [DATA_W-1:0] req1_op2,
   input  logic [DATA_W-1:0] req1_immx,
   input  logic              req1_isImmediate,
   input  logic [CTRL_W-1:0] req1_aluSignals,
   output logic              resp0_valid,
   input  logic              resp0_ready,
   output logic [DATA_W-1:0] resp0_result,
   output logic              resp1_valid,
   input  logic              resp1_ready,
   output logic [DATA_W-1:0] resp1_result,
   output logic [DATA_W-1:0] alu_op1,
   output logic [DATA_W-1:0] alu_op2,
   output logic [DATA_W-1:0] alu_immx,
   output logic              alu_isImmediate,
   output logic [CTRL_W-1:0] alu_aluSignals,
   input  logic [DATA_W-1:0] alu_result,
   output logic              busy,
   output logic              grant_id
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t              state_q, state_d;
   logic                last_grant_q, last_grant_d;
   logic                grant_id_q, grant_id_d;
   logic [DATA_W-1:0]   op1_q, op1_d;
   logic [DATA_W-1:0]   op2_q, op2_d;
   logic [DATA_W-1:0]   immx_q, immx_d;
   logic                isi_q, isi_d;
   logic [CTRL_W-1:0]   sig_q, sig_d;
   logic [DATA_W-1:0]   result_q, result_d;
   logic                grant;
   logic                idle;

   assign idle = (state_q == IDLE);

   // A tie goes to the requester that did not win last time.
   always_comb begin
      grant = 1'b0;
      if (req0_valid && req1_valid) grant = ~last_grant_q;
      else if (req1_valid)          grant = 1'b1;
   end

   // Readies are masked by rst_n so nothing handshakes during reset.
   assign req0_ready = rst_n && idle && req0_valid && !grant;
   assign req1_ready = rst_n && idle && req1_valid && grant;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;
      op1_d        = op1_q;
      op2_d        = op2_q;
      immx_d       = immx_q;
      isi_d        = isi_q;
      sig_d        = sig_q;
      result_d     = result_q;
      unique case (state_q)
         IDLE: begin
            if (req0_ready || req1_ready) begin
               state_d      = EXEC;
               last_grant_d = grant;
               grant_id_d   = grant;
               op1_d        = grant ? req1_op1 : req0_op1;
               op2_d        = grant ? req1_op2 : req0_op2;
               immx_d       = grant ? req1_immx : req0_immx;
               isi_d        = grant ? req1_isImmediate
                                    : req0_isImmediate;
               sig_d        = grant ? req1_aluSignals
                                    : req0_aluSignals;
            end
         end
         EXEC: begin
            result_d = alu_result;
            state_d  = RESP;
         end
         RESP: begin
            if (grant_id_q ? resp1_ready : resp0_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         grant_id_q   <= 1'b0;
         op1_q        <= '0;
         op2_q        <= '0;
         immx_q       <= '0;
         isi_q        <= 1'b0;
         sig_q        <= '0;
         result_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
         op1_q        <= op1_d;
         op2_q        <= op2_d;
         immx_q       <= immx_d;
         isi_q        <= isi_d;
         sig_q        <= sig_d;
         result_q     <= result_d;
      end
   end

   assign resp0_valid     = (state_q == RESP) && !grant_id_q;
   assign resp1_valid     = (state_q == RESP) && grant_id_q;
   assign resp0_result    = result_q;
   assign resp1_result    = result_q;
   assign alu_op1         = op1_q;
   assign alu_op2         = op2_q;
   assign alu_immx        = immx_q;
   assign alu_isImmediate = isi_q;
   assign alu_aluSignals  = sig_q;
   assign busy            = !idle;
   assign grant_id        = grant_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic
// checked against a transaction-level round-robin model.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req0_ready;
   logic [31:0] req0_op1, req0_op2, req0_immx;
   logic        req0_isImmediate;
   logic [4:0]  req0_aluSignals;
   logic        req1_valid, req1_ready;
   logic [31:0] req1_op1, req1_op2, req1_immx;
   logic        req1_isImmediate;
   logic [4:0]  req1_aluSignals;
   logic        resp0_valid, resp0_ready;
   logic [31:0] resp0_result;
   logic        resp1_valid, resp1_ready;
   logic [31:0] resp1_result;
   logic [31:0] alu_op1, alu_op2, alu_immx, alu_result;
   logic        alu_isImmediate;
   logic [4:0]  alu_aluSignals;
   logic        busy, grant_id;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   assign alu_result = alu_op1 + (alu_isImmediate ? alu_immx : alu_op2);

   alu_arbiter #(.DATA_W(32), .CTRL_W(5)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_op1(req0_op1), .req0_op2(req0_op2), .req0_immx(req0_immx),
      .req0_isImmediate(req0_isImmediate),
      .req0_aluSignals(req0_aluSignals),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_op1(req1_op1), .req1_op2(req1_op2), .req1_immx(req1_immx),
      .req1_isImmediate(req1_isImmediate),
      .req1_aluSignals(req1_aluSignals),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
      .resp0_result(resp0_result),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
      .resp1_result(resp1_result),
      .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_immx(alu_immx),
      .alu_isImmediate(alu_isImmediate),
      .alu_aluSignals(alu_aluSignals),
      .alu_result(alu_result),
      .busy(busy), .grant_id(grant_id)
   );

   task automatic clear_inputs();
      req0_valid = 0; req0_op1 = 0; req0_op2 = 0; req0_immx = 0;
      req0_isImmediate = 0; req0_aluSignals = 0;
      req1_valid = 0; req1_op1 = 0; req1_op2 = 0; req1_immx = 0;
      req1_isImmediate = 0; req1_aluSignals = 0;
      resp0_ready = 0; resp1_ready = 0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 0;
      clear_inputs();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst_n = 0;
      req0_valid = 1; req1_valid = 1;
      #1;
      total++; if (req0_ready !== 1'b0) $display("FAIL rst_rdy0 got=%b exp=0", req0_ready); else passed++;
      total++; if (req1_ready !== 1'b0) $display("FAIL rst_rdy1 got=%b exp=0", req1_ready); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else passed++;
      total++; if ({resp0_valid, resp1_valid} !== 2'b00) $display("FAIL rst_rvalid got=%b exp=00", {resp0_valid, resp1_valid}); else passed++;
      total++; if (resp0_result !== 32'h0) $display("FAIL rst_result got=%h exp=0", resp0_result); else passed++;
      total++; if (grant_id !== 1'b0) $display("FAIL rst_grant_id got=%b exp=0", grant_id); else passed++;
      total++; if ({alu_op1, alu_op2, alu_immx} !== 96'h0) $display("FAIL rst_alu_ops got=%h exp=0", {alu_op1, alu_op2, alu_immx}); else passed++;
      total++; if ({alu_isImmediate, alu_aluSignals} !== 6'h0) $display("FAIL rst_alu_ctl got=%h exp=0", {alu_isImmediate, alu_aluSignals}); else passed++;
      @(negedge clk);
      clear_inputs();
      rst_n = 1;
   endtask

   task automatic test_single();
      @(negedge clk);
      req0_valid = 1; req0_op1 = 5; req0_op2 = 7; req0_immx = 32'h55;
      req0_isImmediate = 0; req0_aluSignals = 5'h03; resp0_ready = 0;
      #1;
      total++; if (req0_ready !== 1'b1) $display("FAIL single_rdy0 got=%b exp=1", req0_ready); else passed++;
      total++; if (req1_ready !== 1'b0) $display("FAIL single_rdy1 got=%b exp=0", req1_ready); else passed++;
      @(posedge clk); #1;
      req0_valid = 0;
      total++; if (alu_op1 !== 32'd5) $display("FAIL single_alu_op1 got=%0d exp=5", alu_op1); else passed++;
      total++; if (alu_op2 !== 32'd7) $display("FAIL single_alu_op2 got=%0d exp=7", alu_op2); else passed++;
      total++; if (req0_ready !== 1'b0) $display("FAIL single_rdy0_exec got=%b exp=0", req0_ready); else passed++;
      total++; if (busy !== 1'b1) $display("FAIL single_busy got=%b exp=1", busy); else passed++;
      total++; if (resp0_valid !== 1'b0) $display("FAIL single_early_resp got=%b exp=0", resp0_valid); else passed++;
      @(posedge clk); #1;
      total++; if (resp0_valid !== 1'b1) $display("FAIL single_resp0_valid got=%b exp=1", resp0_valid); else passed++;
      total++; if (resp0_result !== 32'd12) $display("FAIL single_result got=%0d exp=12", resp0_result); else passed++;
      total++; if (resp1_valid !== 1'b0) $display("FAIL single_resp1_valid got=%b exp=0", resp1_valid); else passed++;
      total++; if (grant_id !== 1'b0) $display("FAIL single_grant_id got=%b exp=0", grant_id); else passed++;
      resp0_ready = 1;
      @(posedge clk); #1;
      total++; if (resp0_valid !== 1'b0) $display("FAIL single_resp_clear got=%b exp=0", resp0_valid); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL single_idle got=%b exp=0", busy); else passed++;
      total++; if (alu_op1 !== 32'd5) $display("FAIL single_alu_hold got=%0d exp=5", alu_op1); else passed++;
      resp0_ready = 0;
   endtask

   task automatic test_immediate();
      @(negedge clk);
      req1_valid = 1; req1_op1 = 100; req1_op2 = 1; req1_immx = 32'hFFFF_FFFF;
      req1_isImmediate = 1; req1_aluSignals = 5'h13; resp1_ready = 1;
      #1;
      total++; if (req1_ready !== 1'b1) $display("FAIL imm_rdy1 got=%b exp=1", req1_ready); else passed++;
      @(posedge clk); #1;
      req1_valid = 0;
      total++; if (alu_aluSignals !== 5'h13) $display("FAIL imm_signals got=%h exp=13", alu_aluSignals); else passed++;
      total++; if (alu_isImmediate !== 1'b1) $display("FAIL imm_isimm got=%b exp=1", alu_isImmediate); else passed++;
      total++; if (alu_immx !== 32'hFFFF_FFFF) $display("FAIL imm_immx got=%h exp=ffffffff", alu_immx); else passed++;
      @(posedge clk); #1;
      total++; if (resp1_valid !== 1'b1) $display("FAIL imm_resp1_valid got=%b exp=1", resp1_valid); else passed++;
      total++; if (resp1_result !== 32'd99) $display("FAIL imm_result got=%0d exp=99", resp1_result); else passed++;
      total++; if (resp0_valid !== 1'b0) $display("FAIL imm_resp0_valid got=%b exp=0", resp0_valid); else passed++;
      total++; if (grant_id !== 1'b1) $display("FAIL imm_grant_id got=%b exp=1", grant_id); else passed++;
      @(posedge clk); #1;
      total++; if (busy !== 1'b0) $display("FAIL imm_idle got=%b exp=0", busy); else passed++;
      resp1_ready = 0;
   endtask

   task automatic test_contention();
      int g_id[4];
      int g_cyc[4];
      int n = 0;
      do_reset();
      req0_valid = 1; req0_op1 = 10; req0_op2 = 1;
      req1_valid = 1; req1_op1 = 20; req1_op2 = 2;
      resp0_ready = 1; resp1_ready = 1;
      for (int w = 0; w < 12; w++) begin
         #1;
         total++; if (req0_ready && req1_ready) $display("FAIL cont_both_ready cycle=%0d got=11 exp=not-both", w); else passed++;
         if ((req0_ready || req1_ready) && n < 4) begin
            g_id[n] = int'(req1_ready);
            g_cyc[n] = w;
            n++;
         end
         @(negedge clk);
      end
      req0_valid = 0; req1_valid = 0;
      total++; if (n != 4) $display("FAIL cont_grant_count got=%0d exp=4", n); else passed++;
      for (int i = 0; i < 4; i++) begin
         if (i < n) begin
            total++; if (g_id[i] != i % 2) $display("FAIL cont_grant_id[%0d] got=%0d exp=%0d", i, g_id[i], i % 2); else passed++;
            total++; if (g_cyc[i] != 3 * i) $display("FAIL cont_grant_cyc[%0d] got=%0d exp=%0d", i, g_cyc[i], 3 * i); else passed++;
         end
      end
   endtask

   task automatic test_backpressure();
      req0_valid = 1; req0_op1 = 3; req0_op2 = 4; req0_isImmediate = 0;
      resp0_ready = 0; resp1_ready = 0;
      #1;
      total++; if (req0_ready !== 1'b1) $display("FAIL bp_rdy0 got=%b exp=1", req0_ready); else passed++;
      @(posedge clk); #1;
      req0_valid = 0;
      req1_valid = 1; req1_op1 = 50; req1_op2 = 6; req1_isImmediate = 0;
      @(posedge clk); #1;
      for (int i = 0; i < 10; i++) begin
         total++; if (resp0_valid !== 1'b1) $display("FAIL bp_hold_valid cycle=%0d got=%b exp=1", i, resp0_valid); else passed++;
         total++; if (resp0_result !== 32'd7) $display("FAIL bp_hold_result cycle=%0d got=%0d exp=7", i, resp0_result); else passed++;
         total++; if (req1_ready !== 1'b0) $display("FAIL bp_rdy1_stall cycle=%0d got=%b exp=0", i, req1_ready); else passed++;
         @(posedge clk); #1;
      end
      resp0_ready = 1;
      @(posedge clk); #1;
      resp0_ready = 0;
      total++; if (resp0_valid !== 1'b0) $display("FAIL bp_resp0_clear got=%b exp=0", resp0_valid); else passed++;
      total++; if (req1_ready !== 1'b1) $display("FAIL bp_rdy1_after got=%b exp=1", req1_ready); else passed++;
      resp1_ready = 1;
      @(posedge clk); #1;
      req1_valid = 0;
      @(posedge clk); #1;
      total++; if (resp1_valid !== 1'b1) $display("FAIL bp_resp1_valid got=%b exp=1", resp1_valid); else passed++;
      total++; if (resp1_result !== 32'd56) $display("FAIL bp_resp1_result got=%0d exp=56", resp1_result); else passed++;
      @(posedge clk); #1;
      resp1_ready = 0;
   endtask

   task automatic test_reset_mid_exec();
      @(negedge clk);
      req0_valid = 1; req0_op1 = 9; req0_op2 = 9; req0_immx = 32'h77;
      req0_isImmediate = 0; req0_aluSignals = 5'h1F; resp0_ready = 1;
      #1;
      total++; if (req0_ready !== 1'b1) $display("FAIL rme_rdy0 got=%b exp=1", req0_ready); else passed++;
      @(posedge clk); #1;
      req0_valid = 0;
      total++; if (busy !== 1'b1) $display("FAIL rme_exec_busy got=%b exp=1", busy); else passed++;
      #1 rst_n = 0;
      #1;
      total++; if (busy !== 1'b0) $display("FAIL rme_busy got=%b exp=0", busy); else passed++;
      total++; if ({resp0_valid, resp1_valid} !== 2'b00) $display("FAIL rme_rvalid got=%b exp=00", {resp0_valid, resp1_valid}); else passed++;
      total++; if ({alu_op1, alu_op2, alu_immx} !== 96'h0) $display("FAIL rme_alu_ops got=%h exp=0", {alu_op1, alu_op2, alu_immx}); else passed++;
      total++; if (alu_aluSignals !== 5'h0) $display("FAIL rme_alu_sig got=%h exp=0", alu_aluSignals); else passed++;
      req0_valid = 1; req1_valid = 1; req1_op1 = 1; req1_op2 = 1;
      #1;
      total++; if ({req0_ready, req1_ready} !== 2'b00) $display("FAIL rme_rdy_in_reset got=%b exp=00", {req0_ready, req1_ready}); else passed++;
      @(negedge clk);
      rst_n = 1;
      #1;
      total++; if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL rme_first_grant got=%b exp=10", {req0_ready, req1_ready}); else passed++;
      total++; if (resp0_valid !== 1'b0) $display("FAIL rme_no_stale_resp got=%b exp=0", resp0_valid); else passed++;
      @(posedge clk); #1;
      req0_valid = 0; req1_valid = 0;
      @(posedge clk); #1;
      total++; if (resp0_result !== 32'd18) $display("FAIL rme_result got=%0d exp=18", resp0_result); else passed++;
      @(posedge clk); #1;
      resp0_ready = 0;
   endtask

   task automatic test_random();
      logic [31:0] m_op1[2], m_op2[2], m_imm[2];
      logic        m_isi[2];
      logic [4:0]  m_sig[2];
      bit          has[2];
      bit          outstanding = 0;
      bit          owner = 0;
      bit          last_win = 1;
      bit          win, e0, e1, rv;
      int          edge_n = 0;
      int          acc_edge = 0;
      logic [31:0] exp_res = 0;
      has[0] = 0; has[1] = 0;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            if (!has[k] && $urandom_range(1, 0) == 1) begin
               has[k] = 1;
               m_op1[k] = $urandom; m_op2[k] = $urandom; m_imm[k] = $urandom;
               m_isi[k] = 1'($urandom_range(1, 0));
               m_sig[k] = 5'($urandom_range(31, 0));
            end
         end
         req0_valid = has[0]; req0_op1 = m_op1[0]; req0_op2 = m_op2[0];
         req0_immx = m_imm[0]; req0_isImmediate = m_isi[0]; req0_aluSignals = m_sig[0];
         req1_valid = has[1]; req1_op1 = m_op1[1]; req1_op2 = m_op2[1];
         req1_immx = m_imm[1]; req1_isImmediate = m_isi[1]; req1_aluSignals = m_sig[1];
         resp0_ready = ($urandom_range(3, 0) != 0);
         resp1_ready = ($urandom_range(3, 0) != 0);
         #1;
         e0 = 0; e1 = 0;
         if (!outstanding) begin
            win = (has[0] && has[1]) ? !last_win : has[1];
            e0 = has[0] && !win;
            e1 = has[1] && win;
         end
         rv = outstanding && (edge_n >= acc_edge + 1);
         total++; if (req0_ready !== e0) $display("FAIL rnd_rdy0 cyc=%0d got=%b exp=%b", c, req0_ready, e0); else passed++;
         total++; if (req1_ready !== e1) $display("FAIL rnd_rdy1 cyc=%0d got=%b exp=%b", c, req1_ready, e1); else passed++;
         total++; if (resp0_valid !== (rv && !owner)) $display("FAIL rnd_rv0 cyc=%0d got=%b exp=%b", c, resp0_valid, rv && !owner); else passed++;
         total++; if (resp1_valid !== (rv && owner)) $display("FAIL rnd_rv1 cyc=%0d got=%b exp=%b", c, resp1_valid, rv && owner); else passed++;
         total++; if (busy !== outstanding) $display("FAIL rnd_busy cyc=%0d got=%b exp=%b", c, busy, outstanding); else passed++;
         total++; if (grant_id !== owner) $display("FAIL rnd_grant_id cyc=%0d got=%b exp=%b", c, grant_id, owner); else passed++;
         if (rv) begin
            total++; if (resp0_result !== exp_res) $display("FAIL rnd_result cyc=%0d got=%h exp=%h", c, resp0_result, exp_res); else passed++;
         end
         @(posedge clk);
         edge_n++;
         if (rv && (owner ? resp1_ready : resp0_ready)) begin
            outstanding = 0;
         end else if (e0 || e1) begin
            owner = e1;
            last_win = e1;
            outstanding = 1;
            acc_edge = edge_n;
            exp_res = m_op1[e1] + (m_isi[e1] ? m_imm[e1] : m_op2[e1]);
            has[e1] = 0;
         end
      end
      @(negedge clk);
      clear_inputs();
   endtask

   initial begin
      rst_n = 1;
      clear_inputs();
      test_reset();
      test_single();
      test_immediate();
      test_contention();
      test_backpressure();
      test_reset_mid_exec();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
